truth_table_sequencer: RTL

TRUTH_TABLE_SEQUENCER -- requirements
Module: truth_table_sequencer

---
 rtl/truth_table_sequencer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/truth_table_sequencer.sv
// rtl/truth_table_sequencer.sv - sweeps {x,y,z} through 0..7 and checks f against an expected truth table
// Optional build macro TTSEQ_STOP_ON_FAIL_EN: end the sweep at the first mismatching vector.
module truth_table_sequencer #(
  parameter int DWELL = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] exp_tt,
  input  logic       f,
  output logic       x,
  output logic       y,
  output logic       z,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_cnt,
  output logic [7:0] cap_tt,
  output logic [2:0] fail_idx
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DRIVE  = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

  logic [1:0] state;
  logic [2:0] vec_idx;
  logic [7:0] dwell_cnt;
  logic [7:0] exp_lat;
  logic       pass_q;
  logic [3:0] err_q;
  logic [7:0] cap_q;
  logic [2:0] fail_q;

  logic       last_dwell;
  logic       mismatch;
  logic       stop_fail;
  logic [3:0] err_nxt;

  // f is sampled only on the final cycle a vector is held
  assign last_dwell = (state == S_DRIVE) && (dwell_cnt == DWELL_LAST);
  assign mismatch   = last_dwell && (f != exp_lat[vec_idx]);
  assign err_nxt    = err_q + {3'b000, mismatch};

`ifdef TTSEQ_STOP_ON_FAIL_EN
  assign stop_fail = mismatch;
`else
  assign stop_fail = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      vec_idx   <= 3'd0;
      dwell_cnt <= 8'd0;
      exp_lat   <= 8'd0;
      pass_q    <= 1'b0;
      err_q     <= 4'd0;
      cap_q     <= 8'd0;
      fail_q    <= 3'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            exp_lat   <= exp_tt;
            err_q     <= 4'd0;
            cap_q     <= 8'd0;
            fail_q    <= 3'd0;
            vec_idx   <= 3'd0;
            dwell_cnt <= 8'd0;
            state     <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          if (last_dwell) begin
            cap_q[vec_idx] <= f;
          end
          if (mismatch) begin
            err_q <= err_nxt;
            if (err_q == 4'd0) begin
              fail_q <= vec_idx;
            end
          end
          // a sample taken on the abort cycle is still recorded above
          if (abort) begin
            pass_q <= 1'b0;
            state  <= S_FINISH;
          end else if (last_dwell && ((vec_idx == 3'd7) || stop_fail)) begin
            pass_q <= (err_nxt == 4'd0);
            state  <= S_FINISH;
          end else if (last_dwell) begin
            vec_idx   <= vec_idx + 3'd1;
            dwell_cnt <= 8'd0;
          end else begin
            dwell_cnt <= dwell_cnt + 8'd1;
          end
        end
        S_FINISH: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = (state == S_DRIVE);
  assign done     = (state == S_FINISH);
  assign x        = busy & vec_idx[2];
  assign y        = busy & vec_idx[1];
  assign z        = busy & vec_idx[0];
  assign pass     = pass_q;
  assign err_cnt  = err_q;
  assign cap_tt   = cap_q;
  assign fail_idx = fail_q;

endmodule
